// File: rtl/dcache_pkg.sv
// Shared types and derivations for the direct-mapped data cache controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MEM_ARM = 3'd2,
        MEM_RD  = 3'd3,
        MEM_WR  = 3'd4,
        RESP    = 3'd5
    } state_t;

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_width, input int lines);
        return addr_width - $clog2(lines);
    endfunction

    // Width of the counter that times the RAM strobe; never narrower than 1.
    function automatic int lat_cnt_bits(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the cache lines: one comb read port, one sync write port.
// Latency: read is combinational, write lands on the next rising edge.
// Backpressure: none; a write is accepted every cycle wr_en is high.
//
// Ports: core_clk, rst_n (sync, active-low, clears valid bits only),
//        rd_idx -> rd_vld/rd_tag/rd_dat, wr_en/wr_idx/wr_tag/wr_dat.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int INDEX_BITS = index_bits(16),
    parameter int TAG_BITS   = tag_bits(10, 16),
    parameter int DATA_WIDTH = 8
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_vld,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_dat,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_dat
);

    logic [LINES-1:0]      line_vld;
    logic [TAG_BITS-1:0]   line_tag [LINES];
    logic [DATA_WIDTH-1:0] line_dat [LINES];

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            line_vld <= '0;
        end else if (wr_en) begin
            line_vld[wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the valid bits matter.
    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            line_tag[wr_idx] <= wr_tag;
            line_dat[wr_idx] <= wr_dat;
        end
    end

    assign rd_vld = line_vld[rd_idx];
    assign rd_tag = line_tag[rd_idx];
    assign rd_dat = line_dat[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate byte cache in front of a 1024x8 RAM.
// Latency: read hit 2, read miss 3+MEM_LATENCY, write 2+MEM_LATENCY cycles after accept.
// Backpressure: oReqReady high only in IDLE; oRespValid is a one-cycle pulse with no backpressure.
//
// Ports: CPU request (iReq*/oReqReady), response (oResp*), RAM port
//        (memEnable, oWriteDataEnable, addresses, oDataMemIn, iDataMemOut),
//        saturating statistics (oHitCount, oMissCount).
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReqValid,
    output logic                  oReqReady,
    input  logic                  iReqWrite,
    input  logic [ADDR_WIDTH-1:0] iReqAddress,
    input  logic [DATA_WIDTH-1:0] iReqData,
    output logic                  oRespValid,
    output logic [DATA_WIDTH-1:0] oRespData,
    output logic                  oRespHit,
    output logic                  memEnable,
    output logic                  oWriteDataEnable,
    output logic [ADDR_WIDTH-1:0] oReadDataAddress,
    output logic [ADDR_WIDTH-1:0] oWriteDataAddress,
    output logic [DATA_WIDTH-1:0] oDataMemIn,
    input  logic [DATA_WIDTH-1:0] iDataMemOut,
    output logic [CNT_WIDTH-1:0]  oHitCount,
    output logic [CNT_WIDTH-1:0]  oMissCount
);

    localparam int IB  = index_bits(LINES);
    localparam int TB  = tag_bits(ADDR_WIDTH, LINES);
    localparam int LCW = lat_cnt_bits(MEM_LATENCY);

    state_t state, next_state;

    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  hit_q;
    logic [LCW-1:0]        lat_cnt;
    logic                  lat_done;
    logic                  accept;

    logic                  line_vld;
    logic [TB-1:0]         line_tag;
    logic [DATA_WIDTH-1:0] line_dat;
    logic                  lookup_hit;
    logic                  line_we;
    logic [DATA_WIDTH-1:0] line_wdat;

    logic                  ready_d, mem_en_d, we_d, resp_vld_d, resp_hit_d;
    logic [DATA_WIDTH-1:0] resp_dat_d;

    assign accept     = (state == IDLE) && iReqValid;
    assign lookup_hit = line_vld && (line_tag == req_addr[ADDR_WIDTH-1:IB]);
    assign lat_done   = (lat_cnt == LCW'(MEM_LATENCY - 1));

    // Write hits refresh the cached byte in LOOKUP; read misses fill on the last RAM cycle.
    assign line_we   = ((state == LOOKUP) && req_write && lookup_hit)
                     || ((state == MEM_RD) && lat_done);
    assign line_wdat = (state == LOOKUP) ? req_data : iDataMemOut;

    dcache_line_array #(
        .LINES      (LINES),
        .INDEX_BITS (IB),
        .TAG_BITS   (TB),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lines (
        .core_clk (Clock),
        .rst_n    (Reset),
        .rd_idx   (req_addr[IB-1:0]),
        .rd_vld   (line_vld),
        .rd_tag   (line_tag),
        .rd_dat   (line_dat),
        .wr_en    (line_we),
        .wr_idx   (req_addr[IB-1:0]),
        .wr_tag   (req_addr[ADDR_WIDTH-1:IB]),
        .wr_dat   (line_wdat)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (iReqValid) next_state = LOOKUP;
            LOOKUP:  begin
                if (req_write)       next_state = MEM_WR;
                else if (lookup_hit) next_state = RESP;
                else                 next_state = MEM_ARM;
            end
            MEM_ARM: next_state = MEM_RD;
            MEM_RD:  if (lat_done) next_state = RESP;
            MEM_WR:  if (lat_done) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from next_state so every output comes straight off a flop.
    always_comb begin
        ready_d    = (next_state == IDLE);
        mem_en_d   = (next_state == MEM_RD) || (next_state == MEM_WR);
        // MEM_ARM raises WE with the RAM disabled so the MEM_RD falling edge triggers a read.
        we_d       = (next_state == MEM_ARM) || (next_state == MEM_WR);
        resp_vld_d = (next_state == RESP);
        resp_dat_d = req_data;
        resp_hit_d = hit_q;
        case (state)
            LOOKUP:  begin
                resp_dat_d = line_dat;
                resp_hit_d = lookup_hit;
            end
            MEM_RD:  resp_dat_d = iDataMemOut;
            default: ;
        endcase
    end

    // Latched request, lookup result and RAM strobe timer
    always_ff @(posedge Clock) begin
        if (accept) begin
            req_write <= iReqWrite;
            req_addr  <= iReqAddress;
            req_data  <= iReqData;
        end
        if (state == LOOKUP) begin
            hit_q <= lookup_hit;
        end
        if ((state == MEM_RD) || (state == MEM_WR)) begin
            lat_cnt <= lat_cnt + LCW'(1);
        end else begin
            lat_cnt <= '0;
        end
    end

    // Registered outputs and statistics
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            oReqReady         <= 1'b1;
            oRespValid        <= 1'b0;
            oRespData         <= '0;
            oRespHit          <= 1'b0;
            memEnable         <= 1'b0;
            oWriteDataEnable  <= 1'b0;
            oReadDataAddress  <= '0;
            oWriteDataAddress <= '0;
            oDataMemIn        <= '0;
            oHitCount         <= '0;
            oMissCount        <= '0;
        end else begin
            oReqReady        <= ready_d;
            oRespValid       <= resp_vld_d;
            memEnable        <= mem_en_d;
            oWriteDataEnable <= we_d;
            if (accept) begin
                oReadDataAddress  <= iReqAddress;
                oWriteDataAddress <= iReqAddress;
                oDataMemIn        <= iReqData;
            end
            if (resp_vld_d) begin
                oRespData <= resp_dat_d;
                oRespHit  <= resp_hit_d;
            end
            if (state == LOOKUP) begin
                if (lookup_hit) begin
                    if (oHitCount != '1) oHitCount <= oHitCount + CNT_WIDTH'(1);
                end else begin
                    if (oMissCount != '1) oMissCount <= oMissCount + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller placed directly upstream of the 1024x8 data RAM (RAM_SINGLE_READ_PORT).
- Accepts single-byte load/store requests from the CPU datapath over a valid/ready handshake, serves read hits locally, and drives the RAM port for misses and all writes.
- Keeps saturating hit/miss counters for the cache-statistics report.

Parameters:
- DATA_WIDTH, 8, bits per data word; must equal the RAM DATA_WIDTH.
- ADDR_WIDTH, 10, byte address width; must equal the RAM ADDR_WIDTH.
- LINES, 16, number of cache lines, power of two, at least 2.
- MEM_LATENCY, 2, cycles the RAM strobe is held before data is sampled or the write is considered done, at least 1.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- iReqValid  in  1  request present.
- oReqReady  out  1  controller can accept a request; high only in IDLE.
- iReqWrite  in  1  1 = store, 0 = load.
- iReqAddress  in  ADDR_WIDTH  byte address.
- iReqData  in  DATA_WIDTH  store data.
- oRespValid  out  1  one-cycle completion pulse; no backpressure.
- oRespData  out  DATA_WIDTH  load data, or store data echoed for a store.
- oRespHit  out  1  the completed access hit.
- memEnable  out  1  RAM enable.
- oWriteDataEnable  out  1  RAM write enable; its edges trigger the RAM.
- oReadDataAddress  out  ADDR_WIDTH  RAM read address.
- oWriteDataAddress  out  ADDR_WIDTH  RAM write address.
- oDataMemIn  out  DATA_WIDTH  RAM write data.
- iDataMemOut  in  DATA_WIDTH  RAM read data.
- oHitCount  out  CNT_WIDTH  saturating hit count.
- oMissCount  out  CNT_WIDTH  saturating miss count.

Behaviour:
- Reset (Reset==0 at a clock edge):
  - State goes to IDLE and all valid bits clear.
  - All outputs go to 0 except oReqReady, which is 1 from the first cycle after reset.
  - Both counters clear; any in-flight request is dropped with no response.
  - Tag and data arrays are not reset.
- Address split: index = iReqAddress[INDEX_BITS-1:0] with INDEX_BITS = log2(LINES); tag = the upper ADDR_WIDTH-INDEX_BITS bits.
- Accept: iReqValid & oReqReady at an edge latches write, address and data. oReqReady drops on the next cycle. Inputs are ignored until the controller returns to IDLE.
- States:
  - IDLE: wait for a request.
  - LOOKUP: 1 cycle; compare the tag and check the valid bit.
  - Read hit -> RESP.
  - Read miss -> MEM_ARM.
  - Any write -> MEM_WR.
  - MEM_ARM: 1 cycle; memEnable=0, WE=1. This raises WE with the RAM disabled, so nothing is written.
  - MEM_RD: MEM_LATENCY cycles; memEnable=1, WE=0. The falling WE edge triggers the RAM read. iDataMemOut is captured at the last edge, and the line is filled (valid=1, tag, data). Then -> RESP.
  - MEM_WR: MEM_LATENCY cycles; memEnable=1, WE=1, with address and data stable. The rising WE edge writes the RAM. A write hit also updates the cached byte during LOOKUP. A write miss does not allocate. Then -> RESP.
  - RESP: 1 cycle; oRespValid=1, memEnable=0, WE=0; -> IDLE.
- Memory-side rules:
  - All RAM outputs are registered.
  - In IDLE, LOOKUP and RESP: memEnable=0 and WE=0.
  - Address and data are driven from the latched request for the whole access.
- Latency, counted in cycles after the accept edge:
  - read hit: oRespValid in cycle 2.
  - read miss: cycle 3+MEM_LATENCY.
  - write: cycle 2+MEM_LATENCY.
- oRespData and oRespHit are valid only while oRespValid=1 and hold their values otherwise.
- Counters:
  - oHitCount increments on a read hit or a write hit; oMissCount increments on every other access.
  - Each counter updates in the LOOKUP cycle and saturates at all-ones.
- A conflicting-tag read miss overwrites the line unconditionally; no writeback is needed because the cache is write-through.

Decomposition:
- Package dcache_pkg holds:
  - the state enum (IDLE, LOOKUP, MEM_ARM, MEM_RD, MEM_WR, RESP);
  - the INDEX_BITS and TAG_BITS derivation functions;
  - the latency counter width.
- Sub-module dcache_line_array holds the valid/tag/data storage. It has one combinational read port, one synchronous write port, and a synchronous clear of all valid bits on reset.

Test Plan:
- Reset, preload RAM[0x005]=0xA5, read 0x005 -> miss. With MEM_LATENCY=2, oRespValid appears in cycle 5 with oRespData=0xA5 and oRespHit=0; oMissCount=1.
- Read 0x005 again -> oRespValid in cycle 2, data 0xA5, oRespHit=1, memEnable stays 0 throughout, oHitCount=1.
- Read 0x015 (same index, new tag, RAM=0x11) -> miss returning 0x11. A following read of 0x005 misses again and returns 0xA5.
- With 0x005 cached, write 0x005=0x3C -> exactly one WE rising edge with memEnable=1 and RAM[0x005]=0x3C. The next read of 0x005 hits and returns 0x3C.
- Write-miss 0x020=0x77 -> RAM[0x020]=0x77 and no line allocated. The next read of 0x020 misses and returns 0x77.
- Assert Reset during MEM_RD of a read of 0x005:
  - On the next cycle all memory outputs are 0, oReqReady=1, no response is issued and both counters are 0.
  - A following read of 0x005 misses.
